ldpc_decode: RTL and testbench
==============================

# ldpc_decode

Hard-decision bit-flipping decoder for the (8,4) systematic LDPC code used by the LDPCencode stream block. It accepts one 8-bit codeword per packet as a 1-bit Avalon-ST stream and iteratively corrects it against the fixed parity-check matrix. It emits the 4 information bits as a 1-bit Avalon-ST packet, with an error flag on the last beat. It sits on the receive side of the link, mirroring the encoder's stream interface.

## Interface
- MAX_ITER, 4, maximum bit-flip iterations per codeword (1..7)
- clk_clk  in  1  clock, all logic rising-edge
- reset_reset  in  1  asynchronous, active-high reset
- in_startofpacket  in  1  first codeword bit (c0)
- in_endofpacket  in  1  last codeword bit (c7)
- in_valid  in  1  input beat valid
- in_ready  out  1  decoder can accept a beat
- in_in_data  in  1  codeword bit, order c0..c7 = d0,d1,d2,d3,p0,p1,p2,p3
- out_startofpacket  out  1  first info bit (d0)
- out_endofpacket  out  1  last info bit (d3)
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- out_out_data  out  1  decoded info bit, order d0..d3
- out_error  out  1  valid only with out_endofpacket: 1 = syndrome nonzero after MAX_ITER

## Operation
- Check equations (H = [P|I]): r0 = d0^d1^d2^p0, r1 = d1^d2^d3^p1, r2 = d0^d1^d3^p2, r3 = d0^d2^d3^p3; syndrome s = {r3,r2,r1,r0}.
- Per-bit unsatisfied count u: d0 = r0+r2+r3, d1 = r0+r1+r2, d2 = r0+r1+r3, d3 = r1+r2+r3, pi = ri (range 0..3, 2 bits).
- The FSM has states IDLE, COLLECT, DECODE, OUTPUT.
- IDLE: in_ready=1. A beat with sop stores c0, sets bit index 1, and moves to COLLECT. Non-sop beats are discarded.
- COLLECT: in_ready=1. Each accepted beat stores c[idx] and increments idx.
  - A beat with sop restarts collection at c0.
  - A beat with eop at idx<7 drops the packet and returns to IDLE.
  - The beat at idx=7 completes the codeword regardless of eop; iter is cleared and the FSM enters DECODE.
- DECODE: in_ready=0. One iteration per cycle:
  - If s==0, go to OUTPUT with error=0.
  - Else if iter==MAX_ITER, go to OUTPUT with error=1.
  - Else flip every bit whose u equals max(u) over all 8 bits, then iter++.
- OUTPUT: present d0..d3 on successive beats. Advance only on out_valid&&out_ready.
  - sop is on the d0 beat; eop and out_error are on the d3 beat.
  - After the d3 beat transfers, go to IDLE.
- out_error, sop and eop are 0 on any beat where they are not defined above.

## Timing
- Reset (async assert, sync deassert into IDLE): in_ready=0 while reset is asserted, then 1 in IDLE. out_valid, out_startofpacket, out_endofpacket, out_out_data and out_error are all 0. All codeword and iter registers are cleared.
- Input: a transfer occurs on in_valid&&in_ready. Minimum 8 cycles per codeword.
- Decode: 1 to MAX_ITER+1 cycles after the c7 beat.
- First output beat: out_valid rises in the cycle after the decode decision. Outputs are registered and held stable while out_ready=0.
- Best-case latency, c7 accepted to d0 presented: 2 cycles (clean codeword).
- No overlap: in_ready=0 during DECODE and OUTPUT. The next packet is accepted starting in the cycle after the d3 transfer.
- Reset mid-packet or mid-output aborts immediately. No partial packet is emitted after reset.

## Test plan
- Clean codeword 1,0,1,1,0,0,0,1 -> output 1,0,1,1; error=0; d0 presented 2 cycles after c7.
- Single error on d2, input 1,0,0,1,0,0,0,1 -> bit d2 flipped in 1 iteration; output 1,0,1,1; error=0.
- All parity bits inverted, input 1,0,1,1,1,1,1,0 -> all four data bits flip; output 0,1,0,0; error=0 (miscorrection is by design).
- Error on p1, input 1,0,1,1,0,1,0,1, MAX_ITER=4 -> decoder oscillates and stops after 4 flips; output 1,0,1,1; error=1.
- Sink backpressure: out_ready toggled 1,0,0,1,... -> each bit is held until accepted; exactly 4 transfers; sop only on d0, eop and error only on d3.
- Framing and reset:
  - Packet with eop on the 5th beat -> dropped, no output; the next valid packet decodes correctly.
  - sop mid-packet -> collection restarts at that beat.
  - reset_reset asserted during OUTPUT -> out_valid is 0 asynchronously; no further beats are emitted.

Source files
------------

// File: rtl/ldpc_decode_if.sv
// rtl/ldpc_decode_if.sv - codeword-in / info-bits-out stream pair for the LDPC decoder
// The slave side is the decoder; the master side is whatever feeds and drains it.
interface ldpc_decode_if;
  logic in_startofpacket;
  logic in_endofpacket;
  logic in_valid;
  logic in_ready;
  logic in_in_data;
  logic out_startofpacket;
  logic out_endofpacket;
  logic out_valid;
  logic out_ready;
  logic out_out_data;
  logic out_error;

  modport master (
    output in_startofpacket, in_endofpacket, in_valid, in_in_data, out_ready,
    input  in_ready, out_startofpacket, out_endofpacket, out_valid, out_out_data, out_error
  );

  modport slave (
    input  in_startofpacket, in_endofpacket, in_valid, in_in_data, out_ready,
    output in_ready, out_startofpacket, out_endofpacket, out_valid, out_out_data, out_error
  );
endinterface

// File: rtl/ldpc_decode.sv
// rtl/ldpc_decode.sv - hard-decision bit-flipping decoder for the (8,4) systematic LDPC code
// Collects c0..c7 serially, flips max-unsatisfied bits once per cycle, then serialises d0..d3.
module ldpc_decode #(
  parameter int MAX_ITER = 4
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  ldpc_decode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, DECODE, OUTPUT} state_t;
  localparam logic [2:0] MAX_ITER_C = 3'(MAX_ITER);

  state_t     state_q, state_d;
  logic [7:0] cw_q, cw_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] iter_q, iter_d;
  logic [1:0] oidx_q, oidx_d;
  logic       err_flag_q, err_flag_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       out_data_q, out_data_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;
  logic       out_err_q, out_err_d;

  logic [3:0]      syn;
  logic [7:0][1:0] u;
  logic [1:0]      u_max;
  logic [7:0]      flip;
  logic            accept;
  logic            out_fire;
  logic [1:0]      oidx_nxt;

  assign syn[0] = cw_q[0] ^ cw_q[1] ^ cw_q[2] ^ cw_q[4];
  assign syn[1] = cw_q[1] ^ cw_q[2] ^ cw_q[3] ^ cw_q[5];
  assign syn[2] = cw_q[0] ^ cw_q[1] ^ cw_q[3] ^ cw_q[6];
  assign syn[3] = cw_q[0] ^ cw_q[2] ^ cw_q[3] ^ cw_q[7];

  // Only consulted when the syndrome is nonzero, so u_max is always at least 1 there.
  always_comb begin
    u[0] = 2'(syn[0]) + 2'(syn[2]) + 2'(syn[3]);
    u[1] = 2'(syn[0]) + 2'(syn[1]) + 2'(syn[2]);
    u[2] = 2'(syn[0]) + 2'(syn[1]) + 2'(syn[3]);
    u[3] = 2'(syn[1]) + 2'(syn[2]) + 2'(syn[3]);
    u[4] = 2'(syn[0]);
    u[5] = 2'(syn[1]);
    u[6] = 2'(syn[2]);
    u[7] = 2'(syn[3]);
    u_max = '0;
    for (int j = 0; j < 8; j++) begin
      if (u[j] > u_max) u_max = u[j];
    end
    for (int j = 0; j < 8; j++) begin
      flip[j] = (u[j] == u_max);
    end
  end

  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign oidx_nxt = oidx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    idx_d       = idx_q;
    iter_d      = iter_q;
    oidx_d      = oidx_q;
    err_flag_d  = err_flag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (accept && bus.in_startofpacket) begin
          cw_d[0] = bus.in_in_data;
          idx_d   = 3'd1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (bus.in_startofpacket) begin
            cw_d[0] = bus.in_in_data;
            idx_d   = 3'd1;
          end else if (idx_q == 3'd7) begin
            cw_d[7] = bus.in_in_data;
            iter_d  = '0;
            state_d = DECODE;
          end else if (bus.in_endofpacket) begin
            state_d = IDLE;
          end else begin
            cw_d[idx_q] = bus.in_in_data;
            idx_d       = idx_q + 3'd1;
          end
        end
      end
      DECODE: begin
        if (syn == 4'd0 || iter_q == MAX_ITER_C) begin
          err_flag_d  = (syn != 4'd0);
          oidx_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = cw_q[0];
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_err_d   = 1'b0;
          state_d     = OUTPUT;
        end else begin
          cw_d   = cw_q ^ flip;
          iter_d = iter_q + 3'd1;
        end
      end
      OUTPUT: begin
        if (out_fire) begin
          if (oidx_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_data_d  = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_err_d   = 1'b0;
            state_d     = IDLE;
          end else begin
            oidx_d     = oidx_nxt;
            out_data_d = cw_q[{1'b0, oidx_nxt}];
            out_sop_d  = 1'b0;
            out_eop_d  = (oidx_nxt == 2'd3);
            out_err_d  = (oidx_nxt == 2'd3) & err_flag_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == COLLECT);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      cw_q        <= '0;
      idx_q       <= '0;
      iter_q      <= '0;
      oidx_q      <= '0;
      err_flag_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      idx_q       <= idx_d;
      iter_q      <= iter_d;
      oidx_q      <= oidx_d;
      err_flag_q  <= err_flag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_out_data      = out_data_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.out_error         = out_err_q;
endmodule

// File: tb/tb_ldpc_decode.sv
// tb/tb_ldpc_decode.sv - directed table plus randomized check of ldpc_decode against a matrix model
// Beats are driven and outputs sampled on the falling clock edge.
module tb_ldpc_decode;
  localparam int MAXIT = 4;
  localparam logic [7:0] H [4] = '{8'h17, 8'h2E, 8'h4B, 8'h8D};

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  always #5 clk_clk = ~clk_clk;

  ldpc_decode_if bus();
  ldpc_decode #(.MAX_ITER(MAXIT)) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] cw;
    logic [3:0] pat;
    logic [3:0] exp_d;
    logic       exp_e;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mk8(input logic [0:7] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [3:0] mk4(input logic [0:3] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[3:0] = d;
    for (int i = 0; i < 4; i++) c[4+i] = ^(d & H[i][3:0]);
    return c;
  endfunction

  // Syndrome from H rows; each bit's unsatisfied count is the number of failing rows it sits in.
  task automatic ref_decode(input logic [7:0] c_in, output logic [3:0] d, output logic e);
    logic [7:0] c;
    logic [3:0] s;
    int u [8];
    int mx;
    c = c_in;
    e = 1'b0;
    for (int it = 0; it <= MAXIT; it++) begin
      for (int i = 0; i < 4; i++) s[i] = ^(c & H[i]);
      if (s == 4'd0) begin
        e = 1'b0;
        break;
      end
      if (it == MAXIT) begin
        e = 1'b1;
        break;
      end
      mx = 0;
      for (int j = 0; j < 8; j++) begin
        u[j] = 0;
        for (int i = 0; i < 4; i++) if (s[i] && H[i][j]) u[j]++;
        if (u[j] > mx) mx = u[j];
      end
      for (int j = 0; j < 8; j++) if (u[j] == mx) c[j] = ~c[j];
    end
    d = c[3:0];
  endtask

  task automatic drive_beat(input logic s, input logic e, input logic d, output bit ok);
    int n;
    @(negedge clk_clk);
    bus.in_valid = 1'b1;
    bus.in_startofpacket = s;
    bus.in_endofpacket = e;
    bus.in_in_data = d;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk_clk);
      n++;
    end
    ok = bus.in_ready;
  endtask

  task automatic send_packet(input logic [7:0] cw, input string name);
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(i == 0, i == 7, cw[i], ok);
      all_ok &= ok;
    end
    chk({name, " in_ready"}, 32'(all_ok), 32'd1);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
    bus.in_in_data = 1'b0;
  endtask

  task automatic collect(input logic [3:0] pat, output logic [3:0] dat, output logic [3:0] sopm,
                         output logic [3:0] eopm, output logic [3:0] errm, output int ntx,
                         output int lat, output bit stable, output bit post_ok);
    int cyc;
    bit pv, pr;
    logic [4:0] prev, cur;
    ntx = 0; lat = -1; stable = 1'b1; cyc = 0; pv = 1'b0; pr = 1'b0; prev = '0;
    dat = '0; sopm = '0; eopm = '0; errm = '0;
    while (ntx < 4 && cyc < 80) begin
      @(negedge clk_clk);
      cyc++;
      idle_in();
      cur = {bus.out_valid, bus.out_out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_error};
      if (bus.out_valid && lat < 0) lat = cyc;
      if (pv && !pr && cur != prev) stable = 1'b0;
      prev = cur;
      pv = bus.out_valid;
      bus.out_ready = pat[2'(cyc % 4)];
      pr = bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        dat[2'(ntx)]  = bus.out_out_data;
        sopm[2'(ntx)] = bus.out_startofpacket;
        eopm[2'(ntx)] = bus.out_endofpacket;
        errm[2'(ntx)] = bus.out_error;
        ntx++;
      end
    end
    @(negedge clk_clk);
    post_ok = !bus.out_valid && bus.in_ready;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] dat, sopm, eopm, errm;
    int ntx, lat;
    bit stable, post_ok;
    send_packet(v.cw, v.name);
    collect(v.pat, dat, sopm, eopm, errm, ntx, lat, stable, post_ok);
    chk({v.name, " data"}, 32'(dat), 32'(v.exp_d));
    chk({v.name, " error"}, 32'(errm[3]), 32'(v.exp_e));
    chk({v.name, " transfers"}, 32'(ntx), 32'd4);
    chk({v.name, " sop_beats"}, 32'(sopm), 32'h1);
    chk({v.name, " eop_beats"}, 32'(eopm), 32'h8);
    chk({v.name, " err_beats"}, 32'(errm), {28'd0, v.exp_e, 3'd0});
    chk({v.name, " held"}, 32'(stable), 32'd1);
    chk({v.name, " idle_after"}, 32'(post_ok), 32'd1);
    if (v.exp_lat > 0) chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
  endtask

  vec_t tbl [6];
  vec_t rv;
  vec_t clean_v;
  bit ok;
  bit seen;
  logic [3:0] rd;
  logic re;
  logic [7:0] rc;

  initial begin
    tbl[0] = '{"clean",     mk8(8'b10110001), 4'b1111, mk4(4'b1011), 1'b0, 2};
    tbl[1] = '{"d2_err",    mk8(8'b10010001), 4'b1111, mk4(4'b1011), 1'b0, 0};
    tbl[2] = '{"par_inv",   mk8(8'b10111110), 4'b1111, mk4(4'b0100), 1'b0, 0};
    tbl[3] = '{"p1_err",    mk8(8'b10110101), 4'b1111, mk4(4'b1011), 1'b1, 0};
    tbl[4] = '{"backpress", mk8(8'b10110001), 4'b1001, mk4(4'b1011), 1'b0, 2};
    tbl[5] = '{"bp_err",    mk8(8'b10110101), 4'b0110, mk4(4'b1011), 1'b1, 0};
    clean_v = tbl[0];

    idle_in();
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_out_data), 32'd0);
    chk("rst out_sop", 32'(bus.out_startofpacket), 32'd0);
    chk("rst out_eop", 32'(bus.out_endofpacket), 32'd0);
    chk("rst out_error", 32'(bus.out_error), 32'd0);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    chk("idle in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    for (int k = 0; k < 40; k++) begin
      rc = encode(4'($urandom));
      for (int f = 0; f < int'($urandom_range(0, 3)); f++) rc[3'($urandom_range(0, 7))] ^= 1'b1;
      ref_decode(rc, rd, re);
      rv = '{"rand", rc, 4'($urandom_range(1, 15)), rd, re, 0};
      run_vec(rv);
    end

    // eop on the fifth beat drops the packet
    for (int i = 0; i < 5; i++) drive_beat(i == 0, i == 4, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      idle_in();
      bus.out_ready = 1'b1;
      seen |= bus.out_valid;
    end
    bus.out_ready = 1'b0;
    chk("drop no_output", 32'(seen), 32'd0);
    chk("drop in_ready", 32'(bus.in_ready), 32'd1);
    clean_v.name = "after_drop";
    run_vec(clean_v);

    // stray non-sop beats in IDLE, then a restart partway through a packet
    drive_beat(1'b0, 1'b1, 1'b1, ok);
    drive_beat(1'b0, 1'b0, 1'b0, ok);
    for (int i = 0; i < 3; i++) drive_beat(i == 0, 1'b0, 1'b1, ok);
    rv = tbl[1];
    rv.name = "sop_restart";
    run_vec(rv);

    // reset while a decoded word is waiting on the sink
    send_packet(clean_v.cw, "rst_mid");
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_clk);
      idle_in();
      seen = bus.out_valid;
    end
    chk("rst_mid valid_seen", 32'(seen), 32'd1);
    #2 reset_reset = 1'b1;
    #1;
    chk("rst_mid out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_clk);
      seen |= bus.out_valid;
    end
    bus.out_ready = 1'b0;
    chk("rst_mid no_beats", 32'(seen), 32'd0);
    chk("rst_mid in_ready_after", 32'(bus.in_ready), 32'd1);
    clean_v.name = "after_rst";
    run_vec(clean_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
